sevenseg_reader: RTL
====================

SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical valid samples needed to capture a digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port an, input, 4 bits: display anodes, active-low; an[i]=0 selects digit i (digit 0 = least significant nibble).
REQ-005 SHALL have port seg, input, 7 bits: segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
REQ-006 SHALL have port clr_err, input, 1 bit: synchronous clear of err.
REQ-007 SHALL have port value, output, 16 bits: decoded nibbles; digit i at value[4i+3:4i].
REQ-008 SHALL have port digit_valid, output, 4 bits: bit i set once digit i has been captured since reset.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-010 SHALL have port err, output, 1 bit: sticky flag for a stable but undecodable segment pattern.
REQ-011 SHALL have port err_digit, output, 2 bits: index of the digit that most recently set err.

Function
REQ-012 SHALL register an and seg once per clock; all decisions use the registered sample.
REQ-013 SHALL treat a sample as valid only when exactly one bit of an is 0.
REQ-014 SHALL implement states IDLE (no valid sample), COUNT (valid run shorter than STABLE_CYCLES) and HELD (run captured, waiting for change).
REQ-015 SHALL go IDLE->COUNT on a valid sample, with run count 1.
REQ-016 SHALL, in COUNT, increment the run count while the sample equals the previous sample; a differing valid sample restarts the count at 1 in COUNT; an invalid sample goes to IDLE.
REQ-017 SHALL capture on the edge where the run count reaches STABLE_CYCLES, then go to HELD; each run captures exactly once.
REQ-018 SHALL update value and digit_valid at the (STABLE_CYCLES+1)th rising edge after an and seg become steady and valid.
REQ-019 SHALL, in HELD, stay while the sample is unchanged; a differing valid sample goes to COUNT with count 1; an invalid sample goes to IDLE.
REQ-020 SHALL decode hex patterns 0-F: 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10,0x08,0x03,0x46,0x21,0x06,0x0E.
REQ-021 SHALL, on capture of an undecodable pattern, leave the digit's nibble and digit_valid bit unchanged, set err, and load err_digit.
REQ-022 SHALL keep an internal 4-bit frame mask; each successful capture sets its digit's bit.
REQ-023 SHALL pulse frame_valid for one cycle on the edge where the mask becomes 1111, and clear the mask on that same edge.
REQ-024 SHALL clear err on clr_err=1, except that a decode error on the same edge leaves err set (set wins).
REQ-025 SHALL hold the run count at STABLE_CYCLES (no wrap) however long a pattern stays stable.

Reset
REQ-026 SHALL, while rst_n=0, immediately force value=0x0000, digit_valid=0000, frame_valid=0, err=0, err_digit=00, state=IDLE, run count=0, frame mask=0000, and sample registers to an=1111, seg=1111111.
REQ-027 SHALL, if reset occurs mid-run, discard that run; after release a new full STABLE_CYCLES run is needed before capture.

Verification
REQ-028 Bench SHALL apply an=1110, seg=0x30 steady -> value[3:0]=3 and digit_valid=0001 exactly at edge 5 (STABLE_CYCLES=4), not before.
REQ-029 Bench SHALL scan digits 0..3 with patterns 0x08,0x03,0x46,0x21, each held 6 cycles -> value=0xDCBA, single-cycle frame_valid on the fourth capture, mask cleared afterwards.
REQ-030 Bench SHALL apply an=1110, seg=0x30 for 3 cycles, then seg=0x00 -> no capture of 3; value[3:0]=8 after 4 more stable cycles.
REQ-031 Bench SHALL apply an=1100 or an=1111 with any seg for 20 cycles -> no capture, state IDLE, outputs unchanged.
REQ-032 Bench SHALL apply an=1011, seg=0x7F stable -> err=1, err_digit=2, value[11:8] unchanged; then clr_err=1 for one cycle -> err=0.
REQ-033 Bench SHALL assert rst_n=0 after 2 stable cycles of a run -> all outputs zero immediately; after release capture occurs only after a full 4-cycle run.

Source files
------------

// File: rtl/sevenseg_reader.sv
// ---------------------------------------------------------------------------
// sevenseg_reader
// Watches a multiplexed, active-low 4-digit seven-segment display bus and
// reconstructs the hexadecimal value being shown. Each anode/segment
// combination must stay stable for STABLE_CYCLES consecutive registered
// samples before it is captured. This filters out ghosting while the scan
// moves from one digit to the next.
//
// Parameters
//   STABLE_CYCLES : identical valid samples needed for a capture (2..255)
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   an[3:0]      : anodes, active-low, an[i]=0 selects digit i
//   seg[6:0]     : cathodes, active-low, ordered {g,f,e,d,c,b,a}
//   clr_err      : synchronous clear of err (a same-edge decode error wins)
//   value[15:0]  : decoded nibbles, digit i at value[4i+3:4i]
//   digit_valid  : bit i set once digit i has been captured since reset
//   frame_valid  : one-cycle pulse when all four digits have been captured
//   err          : sticky flag, a stable pattern could not be decoded
//   err_digit    : digit index that most recently set err
// ---------------------------------------------------------------------------
module sevenseg_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        clr_err,
   output logic [15:0] value,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic        err,
   output logic [1:0]  err_digit
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_FULL = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [7:0]  run_cnt;
   logic [7:0]  next_cnt;
   logic [3:0]  an_q;
   logic [6:0]  seg_q;
   logic [3:0]  prev_an;
   logic [6:0]  prev_seg;
   logic [3:0]  frame_mask;
   logic [3:0]  mask_next;

   logic        sample_valid;
   logic [1:0]  sample_idx;
   logic        same_sample;
   logic [3:0]  nibble;
   logic        nibble_ok;
   logic        capture;
   logic        good_capture;
   logic        bad_capture;

   // Both buses are registered once, and every decision below uses these
   // copies. The sample registers idle at "all dark". prev_* holds the
   // sample from the cycle before, so a run can be recognised as a
   // sequence of identical samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q     <= 4'b1111;
         seg_q    <= 7'b1111111;
         prev_an  <= 4'b1111;
         prev_seg <= 7'b1111111;
      end else begin
         an_q     <= an;
         seg_q    <= seg;
         prev_an  <= an_q;
         prev_seg <= seg_q;
      end
   end

   // A sample only counts when exactly one anode is driven. The position of
   // that anode is the digit index.
   always_comb begin
      sample_valid = 1'b1;
      sample_idx   = 2'd0;
      case (an_q)
         4'b1110: sample_idx = 2'd0;
         4'b1101: sample_idx = 2'd1;
         4'b1011: sample_idx = 2'd2;
         4'b0111: sample_idx = 2'd3;
         default: sample_valid = 1'b0;
      endcase
      same_sample = (an_q == prev_an) && (seg_q == prev_seg);
   end

   // Converts active-low segment patterns to hex nibbles. Any pattern that
   // is not one of the sixteen hex glyphs is flagged as undecodable.
   always_comb begin
      nibble    = 4'h0;
      nibble_ok = 1'b1;
      case (seg_q)
         7'h40: nibble = 4'h0;
         7'h79: nibble = 4'h1;
         7'h24: nibble = 4'h2;
         7'h30: nibble = 4'h3;
         7'h19: nibble = 4'h4;
         7'h12: nibble = 4'h5;
         7'h02: nibble = 4'h6;
         7'h78: nibble = 4'h7;
         7'h00: nibble = 4'h8;
         7'h10: nibble = 4'h9;
         7'h08: nibble = 4'hA;
         7'h03: nibble = 4'hB;
         7'h46: nibble = 4'hC;
         7'h21: nibble = 4'hD;
         7'h06: nibble = 4'hE;
         7'h0E: nibble = 4'hF;
         default: nibble_ok = 1'b0;
      endcase
   end

   // State and run-count register. Reset discards any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         run_cnt <= 8'd0;
      end else begin
         state   <= next_state;
         run_cnt <= next_cnt;
      end
   end

   // Next-state logic. A changed but valid sample always restarts the run
   // at one. Once HELD, the count stays at its full value, so a long-lived
   // pattern can never be captured a second time.
   always_comb begin
      next_state = state;
      next_cnt   = run_cnt;
      case (state)
         IDLE: begin
            if (sample_valid) begin
               next_state = COUNT;
               next_cnt   = 8'd1;
            end
         end
         COUNT: begin
            if (!sample_valid) begin
               next_state = IDLE;
               next_cnt   = 8'd0;
            end else if (!same_sample) begin
               next_cnt   = 8'd1;
            end else if (run_cnt == CNT_LAST) begin
               next_state = HELD;
               next_cnt   = CNT_FULL;
            end else begin
               next_cnt   = run_cnt + 8'd1;
            end
         end
         HELD: begin
            if (!sample_valid) begin
               next_state = IDLE;
               next_cnt   = 8'd0;
            end else if (!same_sample) begin
               next_state = COUNT;
               next_cnt   = 8'd1;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = 8'd0;
         end
      endcase
   end

   // Output decode. A capture happens on the one edge where a stable run
   // reaches its full length. The capture is then split into a good or a
   // bad capture, depending on whether the pattern decoded.
   always_comb begin
      capture      = (state == COUNT) && sample_valid && same_sample &&
                     (run_cnt == CNT_LAST);
      good_capture = capture && nibble_ok;
      bad_capture  = capture && !nibble_ok;
      mask_next    = frame_mask | (4'b0001 << sample_idx);
   end

   // Captured value, frame tracking and the sticky error flag. A frame
   // completes when every digit has been seen. The mask is cleared on the
   // same edge, so the next frame starts from nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= 16'h0000;
         digit_valid <= 4'b0000;
         frame_valid <= 1'b0;
         frame_mask  <= 4'b0000;
         err         <= 1'b0;
         err_digit   <= 2'd0;
      end else begin
         frame_valid <= 1'b0;
         if (good_capture) begin
            value[sample_idx*4 +: 4] <= nibble;
            digit_valid[sample_idx]  <= 1'b1;
            if (mask_next == 4'b1111) begin
               frame_valid <= 1'b1;
               frame_mask  <= 4'b0000;
            end else begin
               frame_mask  <= mask_next;
            end
         end
         if (bad_capture) begin
            err       <= 1'b1;
            err_digit <= sample_idx;
         end else if (clr_err) begin
            err       <= 1'b0;
         end
      end
   end

endmodule
